// File: rtl/writeback_stage_if.sv
// MEM->WB stage bundle: M-side pipeline fields, hazard controls and W-side register-file results.
// master drives the M fields and controls; slave is the writeback stage itself.
interface writeback_stage_if #(parameter int XLEN = 32);
   logic            RegWriteM;
   logic [1:0]      ResultSrcM;
   logic [XLEN-1:0] ALUResultM;
   logic [XLEN-1:0] ReadDataM;
   logic [XLEN-1:0] PCPlus4M;
   logic [4:0]      RdM;
   logic [2:0]      Funct3M;
   logic            EXMEM_valid;
   logic            StallW;
   logic            FlushW;
   logic            RegWriteW;
   logic [4:0]      RdW;
   logic [XLEN-1:0] ResultW;
   logic            MEMWB_valid;
   logic            LoadMisalignW;
   logic [63:0]     CycleW;
   logic [63:0]     InstretW;

   modport master (
      output RegWriteM, ResultSrcM, ALUResultM, ReadDataM, PCPlus4M, RdM, Funct3M,
             EXMEM_valid, StallW, FlushW,
      input  RegWriteW, RdW, ResultW, MEMWB_valid, LoadMisalignW, CycleW, InstretW
   );

   modport slave (
      input  RegWriteM, ResultSrcM, ALUResultM, ReadDataM, PCPlus4M, RdM, Funct3M,
             EXMEM_valid, StallW, FlushW,
      output RegWriteW, RdW, ResultW, MEMWB_valid, LoadMisalignW, CycleW, InstretW
   );
endinterface

// File: rtl/writeback_stage.sv
// RV32I writeback: MEM/WB register, load extraction/extension, result mux, misalign detect; WB_PERF_CNT_EN adds cycle/instret counters.
// Latency: 1 cycle from M fields to W outputs, W outputs combinational from the MEM/WB register.
// Backpressure: StallW holds the register, FlushW (higher priority) inserts a bubble.
module writeback_stage #(
   parameter int XLEN = 32
) (
   input  logic           clk,
   input  logic           rst,
   writeback_stage_if.slave wb
);

   logic            valid_q;
   logic            regwrite_q;
   logic [1:0]      resultsrc_q;
   logic [XLEN-1:0] alu_q;
   logic [XLEN-1:0] rdata_q;
   logic [XLEN-1:0] pc4_q;
   logic [4:0]      rd_q;
   logic [2:0]      funct3_q;

   logic            capture;
   logic [XLEN-1:0] byte_shift;
   logic [XLEN-1:0] half_shift;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] result;
   logic            misalign;

   // Funct3 encodings other than byte/half loads are formatted and checked as word loads.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      case (f3)
         3'b000, 3'b100: mis = 1'b0;
         3'b001, 3'b101: mis = off[0];
         default:        mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

   assign capture = !wb.FlushW && !wb.StallW;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= 1'b0;
         regwrite_q  <= 1'b0;
         resultsrc_q <= 2'b00;
         alu_q       <= '0;
         rdata_q     <= '0;
         pc4_q       <= '0;
         rd_q        <= 5'd0;
         funct3_q    <= 3'b000;
      end else if (wb.FlushW) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
      end else if (!wb.StallW) begin
         valid_q     <= wb.EXMEM_valid;
         regwrite_q  <= wb.RegWriteM;
         resultsrc_q <= wb.ResultSrcM;
         alu_q       <= wb.ALUResultM;
         rdata_q     <= wb.ReadDataM;
         pc4_q       <= wb.PCPlus4M;
         rd_q        <= wb.RdM;
         funct3_q    <= wb.Funct3M;
      end
   end

   assign byte_shift = rdata_q >> {alu_q[1:0], 3'b000};
   assign half_shift = rdata_q >> {alu_q[1], 4'b0000};

   always_comb begin
      load_data = rdata_q;
      case (funct3_q)
         3'b000:  load_data = {{(XLEN-8){byte_shift[7]}}, byte_shift[7:0]};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_shift[7:0]};
         3'b001:  load_data = {{(XLEN-16){half_shift[15]}}, half_shift[15:0]};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, half_shift[15:0]};
         default: load_data = rdata_q;
      endcase
   end

   always_comb begin
      result = alu_q;
      case (resultsrc_q)
         2'b01:   result = load_data;
         2'b10:   result = pc4_q;
         default: result = alu_q;
      endcase
   end

   assign misalign = valid_q && (resultsrc_q == 2'b01) && is_misaligned(funct3_q, alu_q[1:0]);

   assign wb.MEMWB_valid   = valid_q;
   assign wb.LoadMisalignW = misalign;
   assign wb.RdW           = rd_q;
   assign wb.ResultW       = result;
   assign wb.RegWriteW     = valid_q && regwrite_q && (rd_q != 5'd0) && !misalign;

`ifdef WB_PERF_CNT_EN
   logic [63:0] cycle_q;
   logic [63:0] instret_q;
   logic        retire;

   // Retirement is counted when the instruction enters WB, so a stalled one counts once.
   assign retire = capture && wb.EXMEM_valid &&
                   !((wb.ResultSrcM == 2'b01) && is_misaligned(wb.Funct3M, wb.ALUResultM[1:0]));

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q   <= 64'd0;
         instret_q <= 64'd0;
      end else begin
         cycle_q <= cycle_q + 64'd1;
         if (retire) begin
            instret_q <= instret_q + 64'd1;
         end
      end
   end

   assign wb.CycleW   = cycle_q;
   assign wb.InstretW = instret_q;
`else
   assign wb.CycleW   = 64'd0;
   assign wb.InstretW = 64'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed bench for writeback_stage against a byte/size-level reference model.
module tb_writeback_stage;

`ifdef WB_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   writeback_stage_if #(.XLEN(32)) wb ();
   writeback_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .wb(wb));

   int n_checks = 0;
   int n_errors = 0;

   // Reference model of what sits in WB.
   bit              m_valid, m_rw, m_known;
   logic [1:0]      m_src;
   logic [31:0]     m_alu, m_rdata, m_pc4;
   logic [4:0]      m_rd;
   logic [2:0]      m_f3;
   longint unsigned m_cycle, m_instret;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned access_size(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction

   function automatic bit misal(input logic [2:0] f3, input logic [31:0] addr);
      return ((addr % 4) % access_size(f3)) != 0;
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
      int unsigned     sz;
      longint unsigned full, v;
      sz   = access_size(f3);
      full = 64'd1 << (8 * sz);
      v    = {32'd0, word};
      v    = (v >> (8 * (addr % 4))) % full;
      if (sz < 4 && f3 < 3'd4 && v >= full / 2) v = v - full;
      return v[31:0];
   endfunction

   function automatic logic [31:0] exp_result();
      case (m_src)
         2'd1:    return load_val(m_f3, m_alu, m_rdata);
         2'd2:    return m_pc4;
         default: return m_alu;
      endcase
   endfunction

   function automatic bit exp_mis();
      return m_valid && m_src == 2'd1 && misal(m_f3, m_alu);
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_valid = 0; m_rw = 0; m_known = 1; m_src = 0; m_alu = 0; m_rdata = 0;
         m_pc4 = 0; m_rd = 0; m_f3 = 0; m_cycle = 0; m_instret = 0;
      end else begin
         m_cycle++;
         if (wb.FlushW) begin
            m_valid = 0; m_rw = 0; m_known = 0;
         end else if (!wb.StallW) begin
            m_valid = wb.EXMEM_valid; m_rw = wb.RegWriteM; m_known = 1;
            m_src = wb.ResultSrcM; m_alu = wb.ALUResultM; m_rdata = wb.ReadDataM;
            m_pc4 = wb.PCPlus4M; m_rd = wb.RdM; m_f3 = wb.Funct3M;
            if (wb.EXMEM_valid && !(wb.ResultSrcM == 2'd1 && misal(wb.Funct3M, wb.ALUResultM)))
               m_instret++;
         end
      end
   endtask

   function automatic longint unsigned exp_cycle();
      return PERF ? m_cycle : 64'd0;
   endfunction

   function automatic longint unsigned exp_instret();
      return PERF ? m_instret : 64'd0;
   endfunction

   task automatic check_model();
      check("valid", wb.MEMWB_valid, m_valid);
      check("misalign", wb.LoadMisalignW, exp_mis());
      check("regwrite", wb.RegWriteW, m_valid && m_rw && m_rd != 0 && !exp_mis());
      if (m_known) begin
         check("rd", wb.RdW, m_rd);
         if (!(m_src == 2'd1 && misal(m_f3, m_alu))) check("result", wb.ResultW, exp_result());
      end
      check("cycle", wb.CycleW, exp_cycle());
      check("instret", wb.InstretW, exp_instret());
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic drive(input logic rw, input logic [1:0] src, input logic [31:0] alu,
                        input logic [31:0] rdata, input logic [31:0] pc4, input logic [4:0] rd,
                        input logic [2:0] f3, input logic v, input logic st, input logic fl);
      wb.RegWriteM = rw; wb.ResultSrcM = src; wb.ALUResultM = alu; wb.ReadDataM = rdata;
      wb.PCPlus4M = pc4; wb.RdM = rd; wb.Funct3M = f3; wb.EXMEM_valid = v;
      wb.StallW = st; wb.FlushW = fl;
   endtask

   task automatic drive_random(input bit allow_ctl);
      logic [2:0] f3_tab [5];
      f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      drive($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
            5'($urandom_range(0, 31)), f3_tab[$urandom_range(0, 4)],
            $urandom_range(0, 9) != 0,
            allow_ctl && $urandom_range(0, 4) == 0, allow_ctl && $urandom_range(0, 9) == 0);
   endtask

   longint unsigned base_i, base_c;

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      step();
      check("reset_result", wb.ResultW, 32'h0);
      check("reset_cycle", wb.CycleW, 64'h0);
      rst = 1'b0;

      // LB / LBU sign handling
      drive(1, 2'b01, 32'h13, 32'h8070_60F0, 32'h0, 5'd5, 3'b000, 1, 0, 0);
      step();
      check("tp1_lb", wb.ResultW, 32'hFFFF_FF80);
      check("tp1_we", wb.RegWriteW, 1'b1);
      check("tp1_rd", wb.RdW, 5'd5);
      drive(1, 2'b01, 32'h13, 32'h8070_60F0, 32'h0, 5'd5, 3'b100, 1, 0, 0);
      step();
      check("tp1_lbu", wb.ResultW, 32'h0000_0080);

      // LHU / LH at offset 2
      drive(1, 2'b01, 32'h12, 32'hBEEF_1234, 32'h0, 5'd6, 3'b101, 1, 0, 0);
      step();
      check("tp2_lhu", wb.ResultW, 32'h0000_BEEF);
      drive(1, 2'b01, 32'h12, 32'hBEEF_1234, 32'h0, 5'd6, 3'b001, 1, 0, 0);
      step();
      check("tp2_lh", wb.ResultW, 32'hFFFF_BEEF);

      // Misaligned then aligned LW
      base_i = exp_instret();
      drive(1, 2'b01, 32'h11, 32'hCAFE_F00D, 32'h0, 5'd7, 3'b010, 1, 0, 0);
      step();
      check("tp3_mis", wb.LoadMisalignW, 1'b1);
      check("tp3_mis_we", wb.RegWriteW, 1'b0);
      check("tp3_mis_instret", wb.InstretW, base_i);
      drive(1, 2'b01, 32'h10, 32'hCAFE_F00D, 32'h0, 5'd7, 3'b010, 1, 0, 0);
      step();
      check("tp3_lw", wb.ResultW, 32'hCAFE_F00D);
      check("tp3_lw_instret", wb.InstretW, base_i + (PERF ? 64'd1 : 64'd0));

      // JAL held by stall, then flush
      base_i = exp_instret();
      drive(1, 2'b10, 32'hDEAD_0000, 32'h0, 32'h0000_0104, 5'd1, 3'b010, 1, 0, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1, 2'b00, $urandom, $urandom, $urandom, 5'd9, 3'b010, 1, 1, 0);
         step();
         check("tp4_hold", wb.ResultW, 32'h0000_0104);
      end
      check("tp4_instret", wb.InstretW, base_i + (PERF ? 64'd1 : 64'd0));
      drive(1, 2'b00, 32'h0, 32'h0, 32'h0, 5'd9, 3'b010, 1, 1, 1);
      step();
      check("tp4_flush_valid", wb.MEMWB_valid, 1'b0);
      check("tp4_flush_we", wb.RegWriteW, 1'b0);

      // x0 write suppressed, then bubbles
      drive(1, 2'b00, 32'h55, 32'h0, 32'h0, 5'd0, 3'b010, 1, 0, 0);
      step();
      check("tp5_x0_we", wb.RegWriteW, 1'b0);
      base_i = exp_instret();
      base_c = exp_cycle();
      drive(1, 2'b00, 32'h55, 32'h0, 32'h0, 5'd3, 3'b010, 0, 0, 0);
      repeat (4) step();
      check("tp5_cycle", wb.CycleW, base_c + (PERF ? 64'd4 : 64'd0));
      check("tp5_instret", wb.InstretW, base_i);

      // Reset in the middle of traffic
      for (int i = 0; i < 10; i++) begin
         drive_random(1'b0);
         wb.EXMEM_valid = 1'b1;
         step();
      end
      drive_random(1'b1);
      wb.StallW = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("tp6_valid", wb.MEMWB_valid, 1'b0);
      check("tp6_we", wb.RegWriteW, 1'b0);
      check("tp6_rd", wb.RdW, 5'd0);
      check("tp6_result", wb.ResultW, 32'h0);
      check("tp6_mis", wb.LoadMisalignW, 1'b0);
      check("tp6_cycle", wb.CycleW, 64'h0);
      check("tp6_instret", wb.InstretW, 64'h0);

      // Random traffic with stalls, flushes and occasional resets
      for (int i = 0; i < 600; i++) begin
         drive_random(1'b1);
         rst = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final pipeline stage of the RV32I core, directly downstream of the memory stage. It holds the MEM/WB pipeline register with a valid bit, hold (stall) and flush controls. It extracts and extends sub-word load data and selects the result written to the register file. It also keeps 64-bit cycle and retired-instruction counters.

Parameters:
XLEN, riscv_pkg::XLEN (32), datapath width; only 32 is supported.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
RegWriteM  in  1  register-write enable from MEM
ResultSrcM  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 ALU
ALUResultM  in  XLEN  ALU result; bits [1:0] are the load byte offset
ReadDataM  in  XLEN  raw aligned word from data memory
PCPlus4M  in  XLEN  PC+4 of the instruction
RdM  in  5  destination register
Funct3M  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
EXMEM_valid  in  1  MEM-stage instruction valid
StallW  in  1  hold the MEM/WB register
FlushW  in  1  invalidate the MEM/WB register
RegWriteW  out  1  register-file write enable
RdW  out  5  register-file write address
ResultW  out  XLEN  register-file write data and forwarding source
MEMWB_valid  out  1  WB-stage instruction valid
LoadMisalignW  out  1  misaligned load in WB
CycleW  out  64  cycle counter
InstretW  out  64  retired-instruction counter

Behaviour:
- Reset, synchronous: every register clears to 0 on a clk edge with rst=1. All outputs are then 0: MEMWB_valid, RegWriteW, RdW, ResultW, LoadMisalignW, CycleW and InstretW.
- Register update priority: rst > FlushW > StallW > capture.
  - FlushW=1: MEMWB_valid<=0 and the stored RegWrite<=0; other fields are don't-care.
  - StallW=1: all fields hold.
  - Otherwise: capture every M input, including EXMEM_valid, Funct3M and ALUResultM[1:0].
- Latency: exactly 1 cycle from the M inputs to the W outputs. All W outputs are combinational from the MEM/WB register.
- Load formatting, from the registered word and offset:
  - LB/LBU select byte offset*8 and sign-/zero-extend it.
  - LH/LHU select the half-word at offset[1]*16 and sign-/zero-extend it.
  - LW passes the word through.
  - Undefined Funct3 values are treated as LW.
- Misalign check: LH/LHU with offset[0]=1, or LW with offset!=0.
  - LoadMisalignW = MEMWB_valid & (ResultSrc==01) & misaligned.
  - Load data is then don't-care.
- ResultW mux: 00 ALU, 01 formatted load, 10 PC+4, 11 ALU.
- Write enable: RegWriteW = MEMWB_valid & RegWrite & (RdW!=0) & !LoadMisalignW. A write to x0 is never asserted.
- Cycle counter: CycleW increments by 1 on every non-reset edge and wraps from 2^64-1 to 0.
- Retired-instruction counter:
  - InstretW increments by 1 on an edge that captures with EXMEM_valid=1 and no misaligned load in the incoming fields. A stalled instruction is counted once.
  - No increment on flush, stall, or capture of a bubble. Wraps like CycleW.
- Simultaneous FlushW and StallW: flush wins. Reset mid-stall clears everything.

Optional Feature:
WB_PERF_CNT_EN
- Defined: CycleW and InstretW are implemented as described above.
- Undefined: neither counter is instantiated, and both outputs are constant 0. Port list and all other behaviour are unchanged.

Test Plan:
1. LB sign extension: ReadDataM=0x8070_60F0, ALUResultM=0x0000_0013, Funct3M=000, ResultSrcM=01, RdM=5, valid=1 -> next cycle ResultW=0xFFFF_FF80, RegWriteW=1, RdW=5. Same stimulus with LBU -> ResultW=0x0000_0080.
2. LHU offset 2: ReadDataM=0xBEEF_1234, addr 0x12, Funct3M=101 -> ResultW=0x0000_BEEF. LH at the same address -> 0xFFFF_BEEF.
3. Misaligned LW at addr 0x11 -> LoadMisalignW=1, RegWriteW=0, InstretW unchanged. Aligned LW at 0x10 -> ResultW=ReadDataM, InstretW+1.
4. Stall, then flush of a JAL result (ResultSrcM=10, PCPlus4M=0x0000_0104, RdM=1):
   - StallW=1 for 3 cycles -> ResultW held at 0x104, InstretW incremented once.
   - Then FlushW=1 with StallW=1 -> MEMWB_valid=0, RegWriteW=0.
5. rd=x0 and bubbles: RegWriteM=1, RdM=0 -> RegWriteW=0. EXMEM_valid=0 for 4 cycles -> CycleW+4, InstretW+0.
6. Reset mid-operation: after 10 cycles of valid instructions, assert rst for 1 cycle -> next cycle all outputs 0. With WB_PERF_CNT_EN undefined, CycleW=InstretW=0 throughout.
